spi_master_xfer_sequencer: RTL and testbench

- Sequences one SPI master transaction on a single-lane, mode-0 bus.
- Serial phase order: CMD, ADDR, DUMMY, WR, RD.
- Accepts a request carrying the same fields the SPI monitor collector reconstructs: cmd/addr/mosi_data values and their lengths.
- Sits between the register front end and the SPI pins; generates SCLK, CSn and SDO, and captures SDI.

---
 rtl/spi_master_xfer_sequencer_pkg.sv | 57 +++++
 rtl/spi_master_xfer_sequencer_sclk_gen.sv | 39 +++
 rtl/spi_master_xfer_sequencer.sv | 149 ++++++++++++++
 tb/tb_spi_master_xfer_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_xfer_sequencer_pkg.sv
// Shared types for the SPI master transfer sequencer: FSM states, request record
// and the phase-ordering helpers.
package spi_master_xfer_pkg;

  localparam int unsigned MAX_LEN = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_WR,
    ST_RD,
    ST_DONE
  } state_e;

  // Field layout mirrors the monitor collector packet.
  typedef struct packed {
    logic [MAX_LEN-1:0] cmd;
    logic [5:0]         cmd_len;
    logic [MAX_LEN-1:0] addr;
    logic [5:0]         addr_len;
    logic [5:0]         dummy_len;
    logic [MAX_LEN-1:0] wr_data;
    logic [5:0]         wr_len;
    logic [5:0]         rd_len;
  } spi_req_s;

  function automatic state_e phase_of(input int unsigned idx);
    state_e s;
    case (idx)
      0:       s = ST_CMD;
      1:       s = ST_ADDR;
      2:       s = ST_DUMMY;
      3:       s = ST_WR;
      4:       s = ST_RD;
      default: s = ST_DONE;
    endcase
    return s;
  endfunction

  // First phase at or after index 'start' with a nonzero length; DONE if none.
  function automatic state_e next_phase(input logic [4:0] nz, input int unsigned start);
    state_e s;
    logic   found;
    s     = ST_DONE;
    found = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (!found && i >= start && nz[i]) begin
        s     = phase_of(i);
        found = 1'b1;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/spi_master_xfer_sequencer_sclk_gen.sv
// SCLK divider: mode-0 clock level plus strobes flagging the HCLK cycle that
// ends each low half (rise) and each high half (fall).
module spi_sclk_gen #(
  parameter int unsigned CLKDIV_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CLKDIV_W-1:0] div,
  output logic                spi_clk,
  output logic                rise_stb,
  output logic                fall_stb
);

  logic [CLKDIV_W-1:0] cnt;
  logic                lvl;
  logic                half_end;

  assign half_end = en && (cnt == div);
  assign rise_stb = half_end && !lvl;
  assign fall_stb = half_end && lvl;
  assign spi_clk  = lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      lvl <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      lvl <= 1'b0;
    end else if (half_end) begin
      cnt <= '0;
      lvl <= ~lvl;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_xfer_sequencer.sv
// Single-lane mode-0 SPI master sequencer: runs CMD, ADDR, DUMMY, WR, RD phases
// for one latched request and returns the received data right-justified.
module spi_master_xfer_sequencer #(
  parameter int unsigned CLKDIV_W = 8,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CLKDIV_W-1:0] clk_div,
  input  logic [DATA_W-1:0]   cmd,
  input  logic [5:0]          cmd_len,
  input  logic [DATA_W-1:0]   addr,
  input  logic [5:0]          addr_len,
  input  logic [5:0]          dummy_len,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [5:0]          wr_len,
  input  logic [5:0]          rd_len,
  output logic                spi_clk,
  output logic                spi_csn,
  output logic                spi_sdo,
  input  logic                spi_sdi,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   rx_data
);

  import spi_master_xfer_pkg::*;

  function automatic logic [5:0] sat_len(input logic [5:0] len);
    return (len > 6'(DATA_W)) ? 6'(DATA_W) : len;
  endfunction

  function automatic logic [4:0] nz_of(input spi_req_s r);
    return {r.rd_len != '0, r.wr_len != '0, r.dummy_len != '0,
            r.addr_len != '0, r.cmd_len != '0};
  endfunction

  function automatic logic [5:0] len_of(input state_e s, input spi_req_s r);
    logic [5:0] l;
    case (s)
      ST_CMD:   l = r.cmd_len;
      ST_ADDR:  l = r.addr_len;
      ST_DUMMY: l = r.dummy_len;
      ST_WR:    l = r.wr_len;
      ST_RD:    l = r.rd_len;
      default:  l = '0;
    endcase
    return l;
  endfunction

  state_e              state, state_next;
  spi_req_s            req_in, req_q;
  logic [CLKDIV_W-1:0] div_q;
  logic [5:0]          bitcnt;
  logic [5:0]          load_len;
  logic [DATA_W-1:0]   rx_shift;
  logic                in_phase;
  logic                rise_stb, fall_stb;
  logic                last_bit;

  always_comb begin
    req_in           = '0;
    req_in.cmd       = cmd;
    req_in.cmd_len   = sat_len(cmd_len);
    req_in.addr      = addr;
    req_in.addr_len  = sat_len(addr_len);
    req_in.dummy_len = sat_len(dummy_len);
    req_in.wr_data   = wr_data;
    req_in.wr_len    = sat_len(wr_len);
    req_in.rd_len    = sat_len(rd_len);
  end

  assign in_phase  = state inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_WR, ST_RD};
  assign last_bit  = fall_stb && (bitcnt == '0);
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign spi_csn   = !in_phase;

  spi_sclk_gen #(
    .CLKDIV_W(CLKDIV_W)
  ) u_sclk (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .en       (in_phase),
    .div      (div_q),
    .spi_clk  (spi_clk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (req_valid) state_next = next_phase(nz_of(req_in), 0);
      ST_CMD:   if (last_bit)  state_next = next_phase(nz_of(req_q), 1);
      ST_ADDR:  if (last_bit)  state_next = next_phase(nz_of(req_q), 2);
      ST_DUMMY: if (last_bit)  state_next = next_phase(nz_of(req_q), 3);
      ST_WR:    if (last_bit)  state_next = next_phase(nz_of(req_q), 4);
      ST_RD:    if (last_bit)  state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    // On accept the request is not latched yet, so lengths come from the inputs.
    load_len = len_of(state_next, (state == ST_IDLE) ? req_in : req_q);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      req_q    <= '0;
      div_q    <= '0;
      bitcnt   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
    end else begin
      if (state == ST_IDLE && req_valid) begin
        req_q    <= req_in;
        div_q    <= clk_div;
        rx_shift <= '0;
      end else if (state == ST_RD && rise_stb) begin
        rx_shift <= {rx_shift[DATA_W-2:0], spi_sdi};
      end
      if (state_next != state)
        bitcnt <= (load_len == '0) ? '0 : load_len - 6'd1;
      else if (fall_stb)
        bitcnt <= bitcnt - 6'd1;
      if (state_next == ST_DONE && state != ST_DONE)
        rx_data <= (state == ST_IDLE) ? '0 : rx_shift;
    end
  end

  always_comb begin
    spi_sdo = 1'b0;
    case (state)
      ST_CMD:  spi_sdo = req_q.cmd[bitcnt[4:0]];
      ST_ADDR: spi_sdo = req_q.addr[bitcnt[4:0]];
      ST_WR:   spi_sdo = req_q.wr_data[bitcnt[4:0]];
      default: spi_sdo = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_spi_master_xfer_sequencer.sv
// Directed bench for spi_master_xfer_sequencer: per-cycle capture after each
// accept, compared against hand-computed bit streams and cycle positions.
module tb_spi_master_xfer_sequencer;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        req_valid, req_ready;
  logic [7:0]  clk_div;
  logic [31:0] cmd, addr, wr_data;
  logic [5:0]  cmd_len, addr_len, dummy_len, wr_len, rd_len;
  logic        spi_clk, spi_csn, spi_sdo, spi_sdi;
  logic        busy, done;
  logic [31:0] rx_data;

  int checks = 0;
  int errors = 0;

  logic        cap_csn   [0:299];
  logic        cap_clk   [0:299];
  logic        cap_sdo   [0:299];
  logic        cap_done  [0:299];
  logic        cap_busy  [0:299];
  logic        cap_ready [0:299];
  logic [31:0] cap_rx    [0:299];

  always #5 HCLK = ~HCLK;

  spi_master_xfer_sequencer #(
    .CLKDIV_W(8),
    .DATA_W  (32)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .clk_div   (clk_div),
    .cmd       (cmd),
    .cmd_len   (cmd_len),
    .addr      (addr),
    .addr_len  (addr_len),
    .dummy_len (dummy_len),
    .wr_data   (wr_data),
    .wr_len    (wr_len),
    .rd_len    (rd_len),
    .spi_clk   (spi_clk),
    .spi_csn   (spi_csn),
    .spi_sdo   (spi_sdo),
    .spi_sdi   (spi_sdi),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required self-termination");
    $fatal(1);
  end

  task automatic set_req(input logic [7:0] d, input logic [31:0] c, input logic [5:0] cl,
                         input logic [31:0] a, input logic [5:0] al, input logic [5:0] dl,
                         input logic [31:0] w, input logic [5:0] wl, input logic [5:0] rl);
    clk_div = d; cmd = c; cmd_len = cl; addr = a; addr_len = al;
    dummy_len = dl; wr_data = w; wr_len = wl; rd_len = rl;
  endtask

  // Raise req_valid at a negedge and return right after the accepting posedge.
  task automatic accept();
    @(negedge HCLK);
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge HCLK);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: req_ready=%b required 1", req_ready);
    end
    @(posedge HCLK);
  endtask

  // Capture cycles T0+1..T0+ncyc; drive SDI for bit slots [rd_start, rd_start+rdlen).
  task automatic run_xfer(input int ncyc, input int per, input int rd_start,
                          input int rdlen, input logic [31:0] rdval, input int release_k);
    int slot;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge HCLK);
      if (k == release_k) req_valid = 1'b0;
      cap_csn[k]   = spi_csn;
      cap_clk[k]   = spi_clk;
      cap_sdo[k]   = spi_sdo;
      cap_done[k]  = done;
      cap_busy[k]  = busy;
      cap_ready[k] = req_ready;
      cap_rx[k]    = rx_data;
      slot = (k - 1) / per;
      if (rdlen > 0 && slot >= rd_start && slot < rd_start + rdlen)
        spi_sdi = rdval[rdlen - 1 - (slot - rd_start)];
      else
        spi_sdi = 1'b0;
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    req_valid = 1'b0;
    spi_sdi = 1'b0;
    set_req(8'd0, 32'd0, 6'd0, 32'd0, 6'd0, 6'd0, 32'd0, 6'd0, 6'd0);
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    checks++; if (spi_csn !== 1'b1) begin errors++; $display("FAIL rst_csn: got %b want 1", spi_csn); end
    checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL rst_clk: got %b want 0", spi_clk); end
    checks++; if (spi_sdo !== 1'b0) begin errors++; $display("FAIL rst_sdo: got %b want 0", spi_sdo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (rx_data !== 32'h0) begin errors++; $display("FAIL rst_rx: got %h want 0", rx_data); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_idle: busy=%b ready=%b want 0/1", busy, req_ready);
    end
  endtask

  task automatic test_cmd_only();
    logic [7:0] obs;
    int lows, dones, clkbad;
    set_req(8'd0, 32'h9F, 6'd8, 32'd0, 6'd0, 6'd0, 32'd0, 6'd0, 6'd0);
    accept();
    run_xfer(18, 2, 0, 0, 32'h0, 1);
    for (int b = 0; b < 8; b++) obs[7-b] = cap_sdo[1 + b*2];
    lows = 0; dones = 0; clkbad = 0;
    for (int k = 1; k <= 16; k++) begin
      if (cap_csn[k] == 1'b0) lows++;
      if (cap_done[k] == 1'b1) dones++;
      if (cap_clk[k] !== (((k - 1) % 2) >= 1)) clkbad++;
    end
    checks++; if (obs !== 8'b10011111) begin errors++; $display("FAIL cmd_sdo: got %b want 10011111", obs); end
    checks++; if (lows != 16) begin errors++; $display("FAIL cmd_csn_low: got %0d cycles want 16", lows); end
    checks++; if (clkbad != 0) begin errors++; $display("FAIL cmd_sclk: %0d bad cycles want 0", clkbad); end
    checks++; if (dones != 0) begin errors++; $display("FAIL cmd_early_done: got %0d want 0", dones); end
    checks++;
    if (cap_done[17] !== 1'b1 || cap_csn[17] !== 1'b1 || cap_clk[17] !== 1'b0 || cap_busy[17] !== 1'b1) begin
      errors++;
      $display("FAIL cmd_end: done=%b csn=%b clk=%b busy=%b want 1/1/0/1",
               cap_done[17], cap_csn[17], cap_clk[17], cap_busy[17]);
    end
    checks++; if (cap_ready[18] !== 1'b1) begin errors++; $display("FAIL cmd_ready_after: got %b want 1", cap_ready[18]); end
  endtask

  task automatic test_read();
    logic [63:0] obs, exp;
    int lows;
    exp = {8'h03, 24'h001234, 32'h0};
    set_req(8'd1, 32'h03, 6'd8, 32'h001234, 6'd24, 6'd0, 32'd0, 6'd0, 6'd32);
    accept();
    run_xfer(258, 4, 32, 32, 32'hDEADBEEF, 1);
    for (int b = 0; b < 64; b++) obs[63-b] = cap_sdo[1 + b*4];
    lows = 0;
    for (int k = 1; k <= 258; k++) if (cap_csn[k] == 1'b0) lows++;
    checks++; if (obs !== exp) begin errors++; $display("FAIL rd_sdo: got %h want %h", obs, exp); end
    checks++; if (lows != 256) begin errors++; $display("FAIL rd_csn_low: got %0d want 256", lows); end
    checks++; if (cap_done[257] !== 1'b1) begin errors++; $display("FAIL rd_done_pos: got %b want 1", cap_done[257]); end
    checks++; if (cap_rx[257] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rx: got %h want deadbeef", cap_rx[257]); end
  endtask

  task automatic test_write();
    logic [19:0] obs;
    int clkbad, dones;
    set_req(8'd3, 32'd0, 6'd0, 32'd0, 6'd0, 6'd4, 32'hA5C3, 6'd16, 6'd0);
    accept();
    run_xfer(162, 8, 0, 0, 32'h0, 1);
    for (int b = 0; b < 20; b++) obs[19-b] = cap_sdo[1 + b*8];
    clkbad = 0; dones = 0;
    for (int k = 1; k <= 160; k++) begin
      if (cap_clk[k] !== (((k - 1) % 8) >= 4)) clkbad++;
      if (cap_done[k] == 1'b1) dones++;
    end
    checks++; if (obs !== {4'h0, 16'hA5C3}) begin errors++; $display("FAIL wr_sdo: got %h want 0a5c3", obs); end
    checks++; if (clkbad != 0) begin errors++; $display("FAIL wr_sclk_period: %0d bad cycles want 0", clkbad); end
    checks++; if (dones != 0 || cap_done[161] !== 1'b1) begin errors++; $display("FAIL wr_done_pos: early=%0d at161=%b want 0/1", dones, cap_done[161]); end
    checks++; if (cap_rx[161] !== 32'h0) begin errors++; $display("FAIL wr_rx_clear: got %h want 0", cap_rx[161]); end
  endtask

  task automatic test_zero_len();
    int csnbad, clkbad;
    set_req(8'd5, 32'hFFFF_FFFF, 6'd0, 32'hFFFF_FFFF, 6'd0, 6'd0, 32'hFFFF_FFFF, 6'd0, 6'd0);
    accept();
    run_xfer(4, 2, 0, 0, 32'h0, 1);
    csnbad = 0; clkbad = 0;
    for (int k = 1; k <= 4; k++) begin
      if (cap_csn[k] !== 1'b1) csnbad++;
      if (cap_clk[k] !== 1'b0) clkbad++;
    end
    checks++; if (cap_done[1] !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", cap_done[1]); end
    checks++; if (csnbad != 0 || clkbad != 0) begin errors++; $display("FAIL zero_bus_idle: csn_bad=%0d clk_bad=%0d want 0/0", csnbad, clkbad); end
    checks++; if (cap_done[2] !== 1'b0 || cap_ready[2] !== 1'b1) begin errors++; $display("FAIL zero_after: done=%b ready=%b want 0/1", cap_done[2], cap_ready[2]); end
  endtask

  task automatic test_saturation_b2b();
    logic [31:0] obs1, obs2;
    int dones;
    set_req(8'd0, 32'hC0FFEE01, 6'd40, 32'd0, 6'd0, 6'd0, 32'd0, 6'd0, 6'd0);
    accept();
    run_xfer(140, 2, 0, 0, 32'h0, 67);
    for (int b = 0; b < 32; b++) begin
      obs1[31-b] = cap_sdo[1 + b*2];
      obs2[31-b] = cap_sdo[67 + b*2];
    end
    dones = 0;
    for (int k = 1; k <= 140; k++) if (cap_done[k] == 1'b1) dones++;
    checks++; if (obs1 !== 32'hC0FFEE01) begin errors++; $display("FAIL sat_sdo: got %h want c0ffee01", obs1); end
    checks++; if (cap_done[65] !== 1'b1) begin errors++; $display("FAIL sat_done_pos: got %b want 1", cap_done[65]); end
    checks++; if (cap_ready[66] !== 1'b1 || cap_csn[66] !== 1'b1) begin errors++; $display("FAIL b2b_gap: ready=%b csn=%b want 1/1", cap_ready[66], cap_csn[66]); end
    checks++; if (cap_csn[67] !== 1'b0) begin errors++; $display("FAIL b2b_restart: csn=%b want 0", cap_csn[67]); end
    checks++; if (obs2 !== 32'hC0FFEE01) begin errors++; $display("FAIL b2b_sdo: got %h want c0ffee01", obs2); end
    checks++; if (cap_done[131] !== 1'b1 || dones != 2) begin errors++; $display("FAIL b2b_done: at131=%b count=%0d want 1/2", cap_done[131], dones); end
  endtask

  task automatic test_reset_mid();
    int dones;
    set_req(8'd1, 32'h03, 6'd8, 32'hABCDEF, 6'd24, 6'd0, 32'd0, 6'd0, 6'd0);
    accept();
    run_xfer(40, 4, 0, 0, 32'h0, 1);
    checks++; if (cap_busy[40] !== 1'b1 || cap_csn[40] !== 1'b0 || cap_clk[40] !== 1'b1) begin
      errors++; $display("FAIL mid_active: busy=%b csn=%b clk=%b want 1/0/1", cap_busy[40], cap_csn[40], cap_clk[40]);
    end
    #1;
    HRESETn = 1'b0;
    #1;
    checks++;
    if (spi_csn !== 1'b1 || spi_clk !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 ||
        done !== 1'b0 || spi_sdo !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: csn=%b clk=%b busy=%b ready=%b done=%b sdo=%b want 1/0/0/1/0/0",
               spi_csn, spi_clk, busy, req_ready, done, spi_sdo);
    end
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      if (done == 1'b1) dones++;
    end
    HRESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      if (done == 1'b1 || spi_csn !== 1'b1) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL mid_no_done: got %0d bad cycles want 0", dones); end
  endtask

  initial begin
    test_reset();
    test_cmd_only();
    test_read();
    test_write();
    test_zero_len();
    test_saturation_b2b();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
